// File: rtl/bound_flasher_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bound_flasher_pkg
//  Purpose  : Shared definitions for the bound flasher controller: phase
//             encoding, default lamp/bound-point values, counter width and
//             phase successor helpers.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package bound_flasher_pkg;

  // Default geometry of the lamp counter and its two bound points.
  localparam int BF_CNT_W  = 5;
  localparam int BF_LAMPS  = 16;
  localparam int BF_MID_LO = 5;
  localparam int BF_MID_HI = 11;

  // Phase codes are exported on the debug port, so the values are fixed.
  typedef enum logic [3:0] {
    PH_SYNC = 4'd0,
    PH_IDLE = 4'd1,
    PH_UP1  = 4'd2,
    PH_DN1  = 4'd3,
    PH_UP2  = 4'd4,
    PH_DN2  = 4'd5,
    PH_UP3  = 4'd6,
    PH_DN3  = 4'd7,
    PH_KB   = 4'd8
  } phase_e;

  // Phase entered when an up-count phase reaches its target.
  function automatic phase_e up_succ(input phase_e ph);
    phase_e r;
    r = PH_SYNC;
    case (ph)
      PH_UP1:  r = PH_DN1;
      PH_UP2:  r = PH_DN2;
      PH_UP3:  r = PH_DN3;
      default: r = PH_SYNC;
    endcase
    return r;
  endfunction

  // Phase entered when a down-count phase reaches its target.
  function automatic phase_e dn_succ(input phase_e ph);
    phase_e r;
    r = PH_SYNC;
    case (ph)
      PH_DN1:  r = PH_UP2;
      PH_DN2:  r = PH_UP3;
      PH_DN3:  r = PH_IDLE;
      default: r = PH_SYNC;
    endcase
    return r;
  endfunction

  // Phase entered when the kickback drain finishes.
  function automatic phase_e kb_succ(input logic ret);
    return ret ? PH_UP3 : PH_UP1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bound_flasher_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bound_flasher_ctrl
//  Purpose  : Sequencing controller for the bound flasher lamp counter.
//             Steers the counter's enb/ison step controls so the lit-lamp
//             count runs 0->LAMPS->MID_LO->MID_HI->0->LAMPS->0 after a flick,
//             with a kickback (drain to 0, then restart) when flick is seen
//             at a bound point during UP1 or UP3.
//  Ports    : clk      - clock, rising edge
//             rst_n    - synchronous active-low reset
//             flick    - start / kickback request (level sampled)
//             state_in - counter value read back (lit lamps)
//             enb      - counter step enable (combinational)
//             ison     - step direction, 1 = up, 0 = down (combinational)
//             busy     - high whenever the phase is not IDLE
//             phase    - current phase code (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module bound_flasher_ctrl
  import bound_flasher_pkg::*;
#(
  parameter int LAMPS  = BF_LAMPS,
  parameter int CNT_W  = BF_CNT_W,
  parameter int MID_LO = BF_MID_LO,
  parameter int MID_HI = BF_MID_HI
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flick,
  input  logic [CNT_W-1:0] state_in,
  output logic             enb,
  output logic             ison,
  output logic             busy,
  output logic [3:0]       phase
);

  localparam logic [CNT_W-1:0] c_lamps  = CNT_W'(LAMPS);
  localparam logic [CNT_W-1:0] c_mid_lo = CNT_W'(MID_LO);
  localparam logic [CNT_W-1:0] c_mid_hi = CNT_W'(MID_HI);
  localparam logic [CNT_W-1:0] c_zero   = '0;
  localparam logic [CNT_W-1:0] c_one    = CNT_W'(1);

  phase_e           phase_q, phase_d;
  logic             ret_q, ret_d;
  logic             w_enb, w_ison, w_kick;
  logic [CNT_W-1:0] w_up_tgt, w_dn_tgt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= PH_SYNC;
      ret_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ret_q   <= ret_d;
    end
  end

  // Targets of the current up/down phase. Values for non-matching phases are
  // never used.
  always_comb begin
    w_up_tgt = (phase_q == PH_UP2) ? c_mid_hi : c_lamps;
    w_dn_tgt = (phase_q == PH_DN1) ? c_mid_lo : c_zero;
  end

  // Kickback is only honoured while climbing in UP1/UP3 at a bound point.
  assign w_kick = flick
                  && ((phase_q == PH_UP1) || (phase_q == PH_UP3))
                  && ((state_in == c_mid_lo) || (state_in == c_mid_hi));

  // --------------------------------------------------------------------------
  // Next-state and step control
  // --------------------------------------------------------------------------
  always_comb begin
    phase_d = phase_q;
    ret_d   = ret_q;
    w_enb   = 1'b0;
    w_ison  = 1'b0;

    case (phase_q)
      PH_SYNC: begin
        // Drain whatever the counter holds; leave on the step that lands on 0.
        if (state_in != c_zero) begin
          w_enb = 1'b1;
          if (state_in == c_one) begin
            phase_d = PH_IDLE;
          end
        end else begin
          phase_d = PH_IDLE;
        end
      end

      PH_IDLE: begin
        if (flick) begin
          phase_d = PH_UP1;
        end
      end

      PH_UP1, PH_UP2, PH_UP3: begin
        w_enb = 1'b1;
        if (w_kick) begin
          // Step down in this very cycle so the drain starts immediately.
          phase_d = PH_KB;
          ret_d   = (phase_q == PH_UP3);
        end else if (state_in >= w_up_tgt) begin
          // Counter is already at/over the target: turn around right away.
          phase_d = up_succ(phase_q);
        end else begin
          w_ison = 1'b1;
          if (state_in == (w_up_tgt - c_one)) begin
            phase_d = up_succ(phase_q);
          end
        end
      end

      PH_DN1, PH_DN2, PH_DN3: begin
        if (state_in == c_zero) begin
          phase_d = dn_succ(phase_q);
        end else begin
          w_enb = 1'b1;
          if (state_in == (w_dn_tgt + c_one)) begin
            phase_d = dn_succ(phase_q);
          end
        end
      end

      PH_KB: begin
        if (state_in != c_zero) begin
          w_enb = 1'b1;
        end
        // Leave on the step reaching 0, or at once if already empty.
        if (state_in <= c_one) begin
          phase_d = kb_succ(ret_q);
          ret_d   = 1'b0;
        end
      end

      default: begin
        phase_d = PH_SYNC;
        ret_d   = 1'b0;
      end
    endcase

    // A read-back beyond the lamp count means the counter is corrupt;
    // resynchronise from scratch.
    if (state_in > c_lamps) begin
      phase_d = PH_SYNC;
      ret_d   = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs. Step controls are forced off while reset is asserted so the
  // counter holds during reset.
  // --------------------------------------------------------------------------
  assign enb   = rst_n & w_enb;
  assign ison  = rst_n & w_ison;
  assign busy  = (phase_q != PH_IDLE);
  assign phase = phase_q;

endmodule
`default_nettype wire

// File: tb/tb_bound_flasher_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bound_flasher_ctrl
//  Purpose  : Self-checking bench for bound_flasher_ctrl. A behavioural lamp
//             counter closes the loop; every counter step is compared against
//             a queue of expected counter values built from the lamp pattern.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bound_flasher_ctrl;
  import bound_flasher_pkg::*;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       flick    = 1'b0;
  logic [4:0] cnt      = 5'd0;
  logic       load     = 1'b0;
  logic [4:0] load_val = 5'd0;
  logic       enb, ison, busy;
  logic [3:0] phase;

  int n_cmp   = 0;
  int n_err   = 0;
  int n_steps = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  bound_flasher_ctrl #(
    .LAMPS (16),
    .CNT_W (5),
    .MID_LO(5),
    .MID_HI(11)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flick   (flick),
    .state_in(cnt),
    .enb     (enb),
    .ison    (ison),
    .busy    (busy),
    .phase   (phase)
  );

  // Lamp counter model driven by the controller.
  always @(posedge clk) begin
    if (load)     cnt <= load_val;
    else if (enb) cnt <= ison ? cnt + 5'd1 : cnt - 5'd1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lamps(input int n);
    int t;
    t = (1 << n) - 1;
    return t & 32'hffff;
  endfunction

  task automatic push_ramp(input int a, input int b);
    if (b > a) for (int v = a + 1; v <= b; v++) exp_q.push_back(v);
    else       for (int v = a - 1; v >= b; v--) exp_q.push_back(v);
  endtask

  task automatic push_nominal();
    push_ramp(0, 16); push_ramp(16, 5); push_ramp(5, 11);
    push_ramp(11, 0); push_ramp(0, 16); push_ramp(16, 0);
  endtask

  // Step monitor: every enabled step is a DUT output event.
  always @(negedge clk) begin
    int nxt;
    if (!load && enb) begin
      nxt = ison ? int'(cnt) + 1 : int'(cnt) - 1;
      n_steps++;
      if (exp_q.size() == 0) check("unexpected_step", nxt, -1);
      else                   check("step", nxt, exp_q.pop_front());
    end
  end

  // Wait (bounded) for a given phase/count pair; returns at posedge+1.
  task automatic wait_for(input int ph, input int v, input string tag);
    int k;
    k = 0;
    do begin
      @(posedge clk); #1; k++;
    end while (!(int'(phase) == ph && int'(cnt) == v) && k < 400);
    check(tag, int'(phase) * 100 + int'(cnt), ph * 100 + v);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (int'(phase) != PH_IDLE && k < 400) begin
      @(posedge clk); #1; k++;
    end
    check(tag, phase, PH_IDLE);
    check({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  task automatic start();
    flick = 1'b1;
    @(posedge clk); #1;
    flick = 1'b0;
    check("start_phase", phase, PH_UP1);
  endtask

  initial begin
    // ---- reset with counter preloaded to 7 ----
    rst_n = 1'b0; load = 1'b1; load_val = 5'd7;
    @(negedge clk);
    check("rst_enb", enb, 0);
    check("rst_ison", ison, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; load = 1'b0;
    check("rst_phase", phase, PH_SYNC);
    check("rst_busy", busy, 1);
    check("rst_cnt", cnt, 7);
    n_steps = 0;
    push_ramp(7, 0);
    wait_idle("sync_drain");
    check("sync_steps", n_steps, 7);
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_enb", enb, 0);
    check("idle_cnt", cnt, 0);

    // ---- nominal run ----
    n_steps = 0;
    push_nominal();
    start();
    wait_for(PH_DN1, 16, "peak");
    check("peak_lamps", lamps(int'(cnt)), 16'hffff);
    wait_for(PH_UP2, 5, "mid_lo_turn");
    check("mid_lo_lamps", lamps(int'(cnt)), 16'h001f);
    check("run_busy", busy, 1);
    wait_idle("nominal_end");
    check("nominal_steps", n_steps, 76);

    // ---- kickback in UP1 at 11 ----
    push_ramp(0, 11); push_ramp(11, 0);
    push_nominal();
    start();
    wait_for(PH_UP1, 11, "kb1_arm");
    flick = 1'b1;
    #1;
    check("kb1_enb", enb, 1);
    check("kb1_ison", ison, 0);
    @(posedge clk); #1;
    check("kb1_phase", phase, PH_KB);
    check("kb1_cnt", cnt, 10);
    repeat (2) @(posedge clk);
    #1;
    flick = 1'b0;
    check("kb1_hold", phase, PH_KB);
    wait_for(PH_UP1, 0, "kb1_return");
    wait_idle("kb1_end");

    // ---- kickback in UP3 at 5 ----
    push_ramp(0, 16); push_ramp(16, 5); push_ramp(5, 11); push_ramp(11, 0);
    push_ramp(0, 5);  push_ramp(5, 0);  push_ramp(0, 16); push_ramp(16, 0);
    start();
    wait_for(PH_UP3, 5, "kb3_arm");
    flick = 1'b1;
    @(posedge clk); #1;
    flick = 1'b0;
    check("kb3_phase", phase, PH_KB);
    check("kb3_cnt", cnt, 4);
    wait_for(PH_UP3, 0, "kb3_return");
    wait_for(PH_DN3, 16, "kb3_peak");
    wait_idle("kb3_end");

    // ---- flick in DN1 / UP2 ignored ----
    n_steps = 0;
    push_nominal();
    start();
    wait_for(PH_DN1, 11, "dn1_flick");
    flick = 1'b1;
    @(posedge clk); #1;
    flick = 1'b0;
    check("dn1_ignore", int'(phase) * 100 + int'(cnt), PH_DN1 * 100 + 10);
    wait_for(PH_UP2, 8, "up2_flick");
    flick = 1'b1;
    @(posedge clk); #1;
    flick = 1'b0;
    check("up2_ignore", int'(phase) * 100 + int'(cnt), PH_UP2 * 100 + 9);
    wait_idle("ignore_end");
    check("ignore_steps", n_steps, 76);

    // ---- reset mid UP2 at 9 ----
    push_ramp(0, 16); push_ramp(16, 5); push_ramp(5, 9);
    start();
    wait_for(PH_UP2, 9, "rst_arm");
    rst_n = 1'b0;
    #1;
    check("midrst_enb", enb, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midrst_phase", phase, PH_SYNC);
    check("midrst_cnt", cnt, 9);
    check("midrst_busy", busy, 1);
    n_steps = 0;
    push_ramp(9, 0);
    wait_idle("midrst_drain");
    check("midrst_steps", n_steps, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
